// File: rtl/impulse_burst_scheduler.sv
// Fires a burst of impulse-generator shots and measures echo time-of-flight per shot.
// TOF counts cycles from the edge that ends FIRE; echoes go through a 2-flop sync plus an edge-detect flop.
module impulse_burst_scheduler #(
  parameter int TOF_W         = 16,
  parameter int WINDOW_CYCLES = 1000,
  parameter int BLANK_CYCLES  = 10,
  parameter int GAP_CYCLES    = 500
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Start,
  input  logic             i_Abort,
  input  logic [7:0]       i_Shot_Count,
  input  logic             i_Gen_Ready,
  output logic             o_Gen_Enable,
  input  logic             i_Echo,
  output logic [TOF_W-1:0] o_Tof,
  output logic             o_Tof_Valid,
  output logic             o_Timeout,
  output logic [7:0]       o_Hit_Count,
  output logic             o_Busy,
  output logic             o_Done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TOF_W-1:0] WIN_LAST  = TOF_W'(WINDOW_CYCLES - 1);
  localparam logic [TOF_W-1:0] BLANK_MIN = TOF_W'(BLANK_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FIRE, S_LISTEN, S_GAP, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [TOF_W-1:0] tof_cnt_q, tof_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       shots_left_q, shots_left_d;
  logic [TOF_W-1:0] tof_q, tof_d;
  logic [7:0]       hit_q, hit_d;
  logic             gen_en_q, gen_en_d;
  logic             tof_vld_q, tof_vld_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic             echo_s1_q, echo_s2_q, echo_s3_q;
  logic             det, det_ok;

  // i_Echo is asynchronous; only the synchronized rising edge is used.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_s3_q <= 1'b0;
    end else begin
      echo_s1_q <= i_Echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
    end
  end

  assign det    = echo_s2_q & ~echo_s3_q;
  assign det_ok = det && (tof_cnt_q >= BLANK_MIN);

  always_comb begin
    state_d      = state_q;
    tof_cnt_d    = tof_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    shots_left_d = shots_left_q;
    tof_d        = tof_q;
    hit_d        = hit_q;
    gen_en_d     = 1'b0;
    tof_vld_d    = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          shots_left_d = i_Shot_Count;
          hit_d        = 8'd0;
          state_d      = (i_Shot_Count == 8'd0) ? S_DONE : S_ARM;
        end
      end
      S_ARM: begin
        if (i_Gen_Ready) begin
          state_d  = S_FIRE;
          gen_en_d = 1'b1;
        end
      end
      S_FIRE: begin
        tof_cnt_d = '0;
        state_d   = S_LISTEN;
      end
      S_LISTEN: begin
        tof_cnt_d = tof_cnt_q + TOF_W'(1);
        // A valid echo on the last window cycle beats the timeout.
        if (det_ok) begin
          tof_d     = tof_cnt_q;
          tof_vld_d = 1'b1;
          if (hit_q != 8'hFF) hit_d = hit_q + 8'd1;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else if (tof_cnt_q == WIN_LAST) begin
          timeout_d = 1'b1;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_LAST) begin
          shots_left_d = shots_left_q - 8'd1;
          state_d      = (shots_left_q == 8'd1) ? S_DONE : S_ARM;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything and suppresses all strobes and result updates.
    if (i_Abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      gen_en_d  = 1'b0;
      tof_vld_d = 1'b0;
      timeout_d = 1'b0;
      tof_d     = tof_q;
      hit_d     = hit_q;
    end

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= S_IDLE;
      tof_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      shots_left_q <= 8'd0;
      tof_q        <= '0;
      hit_q        <= 8'd0;
      gen_en_q     <= 1'b0;
      tof_vld_q    <= 1'b0;
      timeout_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tof_cnt_q    <= tof_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      shots_left_q <= shots_left_d;
      tof_q        <= tof_d;
      hit_q        <= hit_d;
      gen_en_q     <= gen_en_d;
      tof_vld_q    <= tof_vld_d;
      timeout_q    <= timeout_d;
      done_q       <= done_d;
    end
  end

  assign o_Gen_Enable = gen_en_q;
  assign o_Tof        = tof_q;
  assign o_Tof_Valid  = tof_vld_q;
  assign o_Timeout    = timeout_q;
  assign o_Hit_Count  = hit_q;
  assign o_Done       = done_q;
  assign o_Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_impulse_burst_scheduler.sv
// Bench for impulse_burst_scheduler: per-burst stimulus schedule and expected event timeline
// are derived from shot/echo arithmetic, then compared against events seen on the outputs.
module tb_impulse_burst_scheduler;

  localparam int TOF_W = 16;
  localparam int WIN   = 1000;
  localparam int BLANK = 10;
  localparam int GAP   = 500;
  localparam int PLEN  = 8192;

  logic             i_Clk = 1'b0;
  logic             i_Rst_L;
  logic             i_Start;
  logic             i_Abort;
  logic [7:0]       i_Shot_Count;
  logic             i_Gen_Ready;
  logic             o_Gen_Enable;
  logic             i_Echo;
  logic [TOF_W-1:0] o_Tof;
  logic             o_Tof_Valid;
  logic             o_Timeout;
  logic [7:0]       o_Hit_Count;
  logic             o_Busy;
  logic             o_Done;

  impulse_burst_scheduler #(
    .TOF_W(TOF_W), .WINDOW_CYCLES(WIN), .BLANK_CYCLES(BLANK), .GAP_CYCLES(GAP)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start), .i_Abort(i_Abort),
    .i_Shot_Count(i_Shot_Count), .i_Gen_Ready(i_Gen_Ready), .o_Gen_Enable(o_Gen_Enable),
    .i_Echo(i_Echo), .o_Tof(o_Tof), .o_Tof_Valid(o_Tof_Valid), .o_Timeout(o_Timeout),
    .o_Hit_Count(o_Hit_Count), .o_Busy(o_Busy), .o_Done(o_Done)
  );

  always #10 i_Clk = ~i_Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int tof_model = 0;

  // Stimulus indexed by clock edge relative to the edge that samples i_Start (edge 0).
  bit echo_pat  [PLEN];
  bit ready_pat [PLEN];
  int sh_n1 [3];
  int sh_n2 [3];
  int sh_len[3];

  int exp_en[$];
  int exp_res_st[$];
  int exp_res_kind[$];
  int exp_res_tof[$];
  int exp_done;

  function automatic bit echo_at(input int x);
    if (x < 0 || x >= PLEN) return 1'b0;
    return echo_pat[x];
  endfunction

  task automatic put_pulse(input int start, input int len);
    for (int x = start; x < PLEN && (len == 0 || x < start + len); x++) echo_pat[x] = 1'b1;
  endtask

  task automatic set_shot(input int s, input int n1, input int n2, input int len);
    sh_n1[s] = n1; sh_n2[s] = n2; sh_len[s] = len;
  endtask

  // Shot k fires on the first ready edge after arming; echo sampled high at F+n
  // (low at F+n-1) is a hit with tof n+1 if it lands in [BLANK, WIN-1].
  task automatic plan(input int nshots, input int rdy_delay, input bit rdy_rand);
    int a, e, f;
    bit hit;
    for (int x = 0; x < PLEN; x++) begin
      echo_pat[x]  = 1'b0;
      ready_pat[x] = (x < rdy_delay) ? 1'b0 : (rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    end
    exp_en.delete(); exp_res_st.delete(); exp_res_kind.delete(); exp_res_tof.delete();
    a = 0;
    for (int s = 0; s < nshots; s++) begin
      e = a + 1;
      while (e < PLEN - 1 && !ready_pat[e]) e++;
      exp_en.push_back(e);
      f = e + 1;
      if (sh_n1[s] >= 0) put_pulse(f + sh_n1[s], sh_len[s]);
      if (sh_n2[s] >= 0) put_pulse(f + sh_n2[s], sh_len[s]);
      hit = 1'b0;
      for (int k = BLANK; k < WIN && !hit; k++) begin
        if (echo_at(f + k - 1) && !echo_at(f + k - 2)) begin
          hit = 1'b1;
          exp_res_st.push_back(f + k + 1); exp_res_kind.push_back(1); exp_res_tof.push_back(k);
        end
      end
      if (!hit) begin
        exp_res_st.push_back(f + WIN); exp_res_kind.push_back(0); exp_res_tof.push_back(0);
      end
      a = exp_res_st[$] + GAP;
    end
    exp_done = a;
  endtask

  // kill_kind: 0 none, 1 abort sampled at edge kill_at, 2 reset held across edge kill_at.
  task automatic run_burst(input string name, input int nshots, input int kill_kind, input int kill_at);
    int act_en[$], act_st[$], act_kind[$], act_tof[$], act_done[$];
    int r_end, busy_err, hits, exp_tof, r;
    bit busy_exp, ok;
    if (kill_kind != 0) begin
      while (exp_en.size() > 0 && exp_en[$] >= kill_at) void'(exp_en.pop_back());
      while (exp_res_st.size() > 0 && exp_res_st[$] >= kill_at) begin
        void'(exp_res_st.pop_back()); void'(exp_res_kind.pop_back()); void'(exp_res_tof.pop_back());
      end
      if (exp_done >= kill_at) exp_done = -1;
    end
    r_end = (kill_kind != 0) ? kill_at + 700 : exp_done + 3;
    busy_err = 0;
    i_Start = 1'b1; i_Shot_Count = 8'(nshots); i_Echo = echo_pat[0]; i_Gen_Ready = ready_pat[0];
    for (int t = 1; t <= r_end + 1; t++) begin
      @(negedge i_Clk);
      r = t - 1;
      if (o_Gen_Enable) act_en.push_back(r);
      if (o_Tof_Valid) begin act_st.push_back(r); act_kind.push_back(1); act_tof.push_back(int'(o_Tof)); end
      if (o_Timeout)   begin act_st.push_back(r); act_kind.push_back(0); act_tof.push_back(0); end
      if (o_Done) act_done.push_back(r);
      busy_exp = (kill_kind != 0) ? (r < kill_at) : (r <= exp_done);
      if (o_Busy !== busy_exp) busy_err++;
      if (kill_kind != 0 && r == kill_at) begin
        ok = (o_Busy === 1'b0) && (o_Gen_Enable === 1'b0) && (o_Tof_Valid === 1'b0) &&
             (o_Timeout === 1'b0) && (o_Done === 1'b0) &&
             (kill_kind != 2 || (o_Tof === '0 && o_Hit_Count === 8'd0));
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL %s kill_state: busy=%b en=%b vld=%b to=%b done=%b tof=%0d hits=%0d, want all 0 (tof/hits 0 after reset)",
                   name, o_Busy, o_Gen_Enable, o_Tof_Valid, o_Timeout, o_Done, o_Tof, o_Hit_Count);
        end
      end
      i_Start = 1'b0;
      i_Echo = (t < PLEN) ? echo_pat[t] : 1'b0;
      i_Gen_Ready = (t < PLEN) ? ready_pat[t] : 1'b1;
      if (kill_kind == 1) i_Abort = (t == kill_at);
      if (kill_kind == 2) i_Rst_L = (t == kill_at) ? 1'b0 : 1'b1;
    end
    i_Echo = 1'b0; i_Abort = 1'b0; i_Rst_L = 1'b1;
    repeat (4) @(negedge i_Clk);

    n_cmp++;
    if (act_en.size() != exp_en.size()) begin
      n_bad++;
      $display("FAIL %s enable_count: got %0d want %0d", name, act_en.size(), exp_en.size());
    end
    for (int i = 0; i < exp_en.size() && i < act_en.size(); i++) begin
      n_cmp++;
      if (act_en[i] != exp_en[i]) begin
        n_bad++;
        $display("FAIL %s enable_edge[%0d]: got %0d want %0d", name, i, act_en[i], exp_en[i]);
      end
    end
    n_cmp++;
    if (act_st.size() != exp_res_st.size()) begin
      n_bad++;
      $display("FAIL %s result_count: got %0d want %0d", name, act_st.size(), exp_res_st.size());
    end
    for (int i = 0; i < exp_res_st.size() && i < act_st.size(); i++) begin
      n_cmp++;
      if (act_st[i] != exp_res_st[i] || act_kind[i] != exp_res_kind[i] || act_tof[i] != exp_res_tof[i]) begin
        n_bad++;
        $display("FAIL %s result[%0d]: got edge=%0d hit=%0d tof=%0d want edge=%0d hit=%0d tof=%0d",
                 name, i, act_st[i], act_kind[i], act_tof[i], exp_res_st[i], exp_res_kind[i], exp_res_tof[i]);
      end
    end
    n_cmp++;
    if (exp_done < 0 ? (act_done.size() != 0) : (act_done.size() != 1 || act_done[0] != exp_done)) begin
      n_bad++;
      $display("FAIL %s done: got %0d strobes (first at %0d) want edge %0d (-1 = none)",
               name, act_done.size(), (act_done.size() > 0) ? act_done[0] : -1, exp_done);
    end
    n_cmp++;
    if (busy_err != 0) begin
      n_bad++;
      $display("FAIL %s busy_profile: got %0d wrong cycles want 0", name, busy_err);
    end

    hits = 0;
    exp_tof = (kill_kind == 2) ? 0 : tof_model;
    if (kill_kind != 2) begin
      for (int i = 0; i < exp_res_kind.size(); i++) begin
        if (exp_res_kind[i] == 1) begin hits++; exp_tof = exp_res_tof[i]; end
      end
    end
    tof_model = exp_tof;
    n_cmp++;
    if (o_Tof !== TOF_W'(exp_tof) || o_Hit_Count !== 8'(hits)) begin
      n_bad++;
      $display("FAIL %s final: got tof=%0d hits=%0d want tof=%0d hits=%0d", name, o_Tof, o_Hit_Count, exp_tof, hits);
    end
  endtask

  task automatic test_reset();
    i_Rst_L = 1'b0; i_Start = 1'b0; i_Abort = 1'b0; i_Shot_Count = 8'd0;
    i_Gen_Ready = 1'b1; i_Echo = 1'b0;
    repeat (3) @(negedge i_Clk);
    n_cmp++;
    if ({o_Gen_Enable, o_Tof_Valid, o_Timeout, o_Busy, o_Done} !== 5'b0 || o_Tof !== '0 || o_Hit_Count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got en=%b vld=%b to=%b busy=%b done=%b tof=%0d hits=%0d want all 0",
               o_Gen_Enable, o_Tof_Valid, o_Timeout, o_Busy, o_Done, o_Tof, o_Hit_Count);
    end
    i_Rst_L = 1'b1;
    repeat (3) @(negedge i_Clk);
    n_cmp++;
    if (o_Busy !== 1'b0 || o_Gen_Enable !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b en=%b want 0 0", o_Busy, o_Gen_Enable);
    end
    tof_model = 0;
  endtask

  task automatic test_single_echo();
    set_shot(0, 100, -1, 3);
    plan(1, 0, 1'b0);
    run_burst("single_echo", 1, 0, 0);
  endtask

  task automatic test_three_shots();
    set_shot(0, -1, -1, 1); set_shot(1, 200, -1, 4); set_shot(2, -1, -1, 1);
    plan(3, 0, 1'b0);
    run_burst("three_shots", 3, 0, 0);
  endtask

  task automatic test_blanking();
    set_shot(0, 5, 50, 2);
    plan(1, 0, 1'b0);
    run_burst("blanking", 1, 0, 0);
  endtask

  task automatic test_ready_stall();
    set_shot(0, 80, -1, 2);
    plan(1, 301, 1'b0);
    run_burst("ready_stall", 1, 0, 0);
  endtask

  task automatic test_zero_shots();
    plan(0, 0, 1'b0);
    run_burst("zero_shots", 0, 0, 0);
  endtask

  task automatic test_echo_held();
    set_shot(0, 100, -1, 0); set_shot(1, -1, -1, 1);
    plan(2, 0, 1'b0);
    run_burst("echo_held", 2, 0, 0);
  endtask

  task automatic test_window_edge();
    set_shot(0, WIN - 2, -1, 2); set_shot(1, WIN - 1, -1, 2);
    plan(2, 0, 1'b0);
    run_burst("window_edge", 2, 0, 0);
  endtask

  task automatic test_reset_mid_listen();
    set_shot(0, 300, -1, 2); set_shot(1, 40, -1, 2);
    plan(2, 0, 1'b0);
    run_burst("reset_listen", 2, 2, exp_en[0] + 1 + 50);
    set_shot(0, 150, -1, 2); set_shot(1, 30, -1, 2);
    plan(2, 0, 1'b0);
    run_burst("after_reset", 2, 0, 0);
  endtask

  task automatic test_abort_mid_gap();
    set_shot(0, 60, -1, 2); set_shot(1, 70, -1, 2);
    plan(2, 0, 1'b0);
    run_burst("abort_gap", 2, 1, exp_res_st[0] + 250);
    set_shot(0, 20, -1, 2); set_shot(1, -1, -1, 1);
    plan(2, 3, 1'b0);
    run_burst("after_abort", 2, 0, 0);
  endtask

  task automatic test_random();
    int n, l, n1;
    for (int b = 0; b < 6; b++) begin
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3));
      for (int s = 0; s < 3; s++) begin
        l  = int'($urandom_range(1, 8));
        n1 = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 1100));
        set_shot(s, n1, (n1 >= 0 && $urandom_range(0, 1) == 1) ? n1 + l + 1 + int'($urandom_range(0, 300)) : -1, l);
      end
      plan(n, int'($urandom_range(0, 20)), ($urandom_range(0, 1) == 1));
      run_burst($sformatf("random%0d", b), n, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_echo();
    test_three_shots();
    test_blanking();
    test_ready_stall();
    test_zero_shots();
    test_echo_held();
    test_window_edge();
    test_reset_mid_listen();
    test_abort_mid_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
